// File: rtl/proc_pkg.sv
// Shared pipeline types for the 32-bit core.
// Field positions, IF/ID queue states and the decoded-entry bundle.
package proc_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int IMM_W  = 12;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 23;
  localparam int RN_MSB  = 22;
  localparam int RN_LSB  = 19;
  localparam int RM_MSB  = 18;
  localparam int RM_LSB  = 15;
  localparam int IMM_BIT = 31;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [4:0]        opcode;
    logic [3:0]        rd;
    logic [3:0]        rn;
    logic [3:0]        rm;
    logic              use_imm;
    logic [IMM_W-1:0]  imm12;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

endpackage

// File: rtl/instr_field_decode.sv
// Combinational instruction field extraction.
// Splits a raw instruction word into the decoded-entry bundle.
import proc_pkg::*;

module instr_field_decode (
  input  logic [DATA_W-1:0] instr,
  input  logic [ADDR_W-1:0] pc,
  output dec_t              dec
);

  logic unused_bits;

  assign unused_bits = ^instr[RM_LSB-1:IMM_W];

  // pure wiring from instruction bits to fields
  always_comb begin
    dec         = '0;
    dec.pc      = pc;
    dec.opcode  = instr[OPC_MSB:OPC_LSB];
    dec.rd      = instr[RD_MSB:RD_LSB];
    dec.rn      = instr[RN_MSB:RN_LSB];
    dec.rm      = instr[RM_MSB:RM_LSB];
    dec.use_imm = instr[IMM_BIT];
    dec.imm12   = instr[IMM_W-1:0];
  end

endmodule

// File: rtl/if_id_decode_reg.sv
// IF/ID register: 2-entry skid queue with registered field decode.
// Optional stall counter enabled by defining STALL_CNT_EN.
import proc_pkg::*;

module if_id_decode_reg #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [4:0]        out_opcode,
  output logic [3:0]        out_rd,
  output logic [3:0]        out_rn,
  output logic [3:0]        out_rm,
  output logic              out_use_imm,
  output logic [IMM_W-1:0]  out_imm12
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  state_t            state;
  state_t            state_nx;
  dec_t              head;
  dec_t              dec;
  logic [DATA_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_pc;
  logic [DATA_W-1:0] cap_instr;
  logic [ADDR_W-1:0] cap_pc;
  logic              accept;
  logic              pop;
  logic              load_head;
  logic              load_skid;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // promotion from skid re-decodes the stored raw word
  assign cap_instr = (state == FULL) ? skid_instr : in_instr;
  assign cap_pc    = (state == FULL) ? skid_pc : in_pc;

  instr_field_decode u_dec (
    .instr (cap_instr),
    .pc    (cap_pc),
    .dec   (dec)
  );

  // next state and load enables; flush overrides everything
  always_comb begin
    state_nx  = state;
    load_head = 1'b0;
    load_skid = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nx  = ONE;
            load_head = 1'b1;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            state_nx  = FULL;
            load_skid = 1'b1;
          end else if (pop && !accept) begin
            state_nx  = EMPTY;
          end else if (accept && pop) begin
            load_head = 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            state_nx  = ONE;
            load_head = 1'b1;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  // queue state and entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      head       <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      state <= state_nx;
      if (load_head) head <= dec;
      if (load_skid) begin
        skid_instr <= in_instr;
        skid_pc    <= in_pc;
      end
    end
  end

  assign out_pc      = head.pc;
  assign out_opcode  = head.opcode;
  assign out_rd      = head.rd;
  assign out_rn      = head.rn;
  assign out_rm      = head.rm;
  assign out_use_imm = head.use_imm;
  assign out_imm12   = head.imm12;

`ifdef STALL_CNT_EN
  // saturating count of cycles the head waits on decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_decode_reg.sv
// Directed bench for if_id_decode_reg.
// Define STALL_CNT_EN to also cover the stall counter.
module tb_if_id_decode_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_opcode;
  logic [3:0]  out_rd;
  logic [3:0]  out_rn;
  logic [3:0]  out_rm;
  logic        out_use_imm;
  logic [11:0] out_imm12;
`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_id_decode_reg dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_opcode  (out_opcode),
    .out_rd      (out_rd),
    .out_rn      (out_rn),
    .out_rm      (out_rm),
    .out_use_imm (out_use_imm),
    .out_imm12   (out_imm12)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_instr = {pc[7:0], pc[7:0], pc[7:0], pc[7:0]};
  endtask

  logic [31:0] pcs[$];
  int          cycs[$];
  int          vcnt;
  logic        acc;

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'h40);
    tick();
    tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_imm", {20'd0, out_imm12}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    // single instruction decode
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h8A4C_8ABC;
    in_pc     = 32'h100;
    tick();
    in_valid = 1'b0;
    chk("sgl_valid", {31'd0, out_valid}, 32'd1);
    chk("sgl_opc", {27'd0, out_opcode}, 32'h11);
    chk("sgl_rd", {28'd0, out_rd}, 32'h4);
    chk("sgl_rn", {28'd0, out_rn}, 32'h9);
    chk("sgl_rm", {28'd0, out_rm}, 32'h9);
    chk("sgl_uimm", {31'd0, out_use_imm}, 32'd1);
    chk("sgl_imm", {20'd0, out_imm12}, 32'hABC);
    chk("sgl_pc", out_pc, 32'h100);
    tick();
    chk("sgl_drain", {31'd0, out_valid}, 32'd0);

    // back-pressure fills the skid, third word held
    out_ready = 1'b0;
    drive(1'b1, 32'h100);
    tick();
    chk("bp_ready1", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'h104);
    tick();
    chk("bp_ready2", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'h108);
    tick();
    chk("bp_held_rdy", {31'd0, in_ready}, 32'd0);
    chk("bp_held_pc", out_pc, 32'h100);
    out_ready = 1'b1;
    pcs.delete();
    for (int c = 0; c < 8; c++) begin
      if (out_valid) pcs.push_back(out_pc);
      acc = in_valid & in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    chk("bp_count", pcs.size(), 32'd3);
    if (pcs.size() == 3) begin
      chk("bp_pc0", pcs[0], 32'h100);
      chk("bp_pc1", pcs[1], 32'h104);
      chk("bp_pc2", pcs[2], 32'h108);
    end

    // streaming at full rate
    pcs.delete();
    cycs.delete();
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drive(1'b1, 32'h200 + 32'(4 * c));
      else in_valid = 1'b0;
      if (out_valid) begin
        pcs.push_back(out_pc);
        cycs.push_back(c);
      end
      tick();
    end
    chk("st_count", pcs.size(), 32'd8);
    if (pcs.size() == 8) begin
      chk("st_first_cyc", cycs[0], 32'd1);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("st_pc%0d", i), pcs[i], 32'h200 + 32'(4 * i));
        chk($sformatf("st_cyc%0d", i), cycs[i], 32'(1 + i));
      end
    end

    // flush while full with a word offered
    out_ready = 1'b0;
    drive(1'b1, 32'h300);
    tick();
    drive(1'b1, 32'h304);
    tick();
    chk("fl_full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'h308);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) vcnt++;
      tick();
    end
    chk("fl_none", vcnt, 32'd0);
    drive(1'b1, 32'h30C);
    tick();
    in_valid = 1'b0;
    chk("fl_after_v", {31'd0, out_valid}, 32'd1);
    chk("fl_after_pc", out_pc, 32'h30C);
    tick();

    // asynchronous reset while full
    out_ready = 1'b0;
    drive(1'b1, 32'h400);
    tick();
    drive(1'b1, 32'h404);
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_empty", {31'd0, out_valid}, 32'd0);

`ifdef STALL_CNT_EN
    begin
      logic [15:0] s0;
      out_ready = 1'b0;
      drive(1'b1, 32'h500);
      tick();
      in_valid = 1'b0;
      s0 = stall_cnt;
      for (int c = 0; c < 5; c++) tick();
      chk("sc_delta", 32'(stall_cnt - s0), 32'd5);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
